draw_request_scheduler: RTL

- Parametrised successor to the character-request stack and feeder pair.
- Buffers character draw requests (id, x, y) in one queue, selectable as FIFO or LIFO at elaboration.
- Issues one request at a time to the loader and stencil path, and tracks load/draw completion with a handshake.
- Optionally holds new issues until vertical blanking; reports occupancy, overflow and a flush control.

---
 rtl/draw_request_scheduler.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/draw_request_scheduler.sv
// Character draw request queue (FIFO or LIFO) feeding a single load/draw transaction engine.
// Optional screen-bounds rejection of incoming requests is enabled by defining DRAW_CLIP_EN.
module draw_request_scheduler #(
  parameter int ID_WIDTH    = 8,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int DEPTH       = 16,
  parameter int LIFO        = 0,
  parameter int VBLANK_GATE = 1,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ID_WIDTH-1:0]      push_id,
  input  logic [X_WIDTH-1:0]       push_x,
  input  logic [Y_WIDTH-1:0]       push_y,
  input  logic                     flush,
  input  logic                     vblank,
  output logic                     load,
  output logic [ID_WIDTH-1:0]      load_character_id,
  output logic [X_WIDTH-1:0]       load_x,
  output logic [Y_WIDTH-1:0]       load_y,
  input  logic                     load_finish,
  input  logic                     draw_finish,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
`ifdef DRAW_CLIP_EN
  output logic                     clipped,
`endif
  output logic                     overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ID_WIDTH + X_WIDTH + Y_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [ENTRY_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_r, wr_ptr_r;
  logic [PTR_W-1:0]     rd_idx_s, wr_idx_s;
  logic [CNT_W-1:0]     count_r, count_nxt_s;
  logic                 full_r, empty_r, overflow_r, busy_r;
  logic                 load_r;
  logic [ID_WIDTH-1:0]  load_id_r;
  logic [X_WIDTH-1:0]   load_x_r;
  logic [Y_WIDTH-1:0]   load_y_r;
  logic [ENTRY_W-1:0]   rd_entry_s;
  logic                 issue_ok_s, pop_s, clip_s, push_ok_s, drop_s;

  // Request qualification: gating, clip check, accept/drop decisions
  always_comb begin
    issue_ok_s = 1'b0;
    clip_s     = 1'b0;
    if (VBLANK_GATE != 32'sd0) begin
      issue_ok_s = vblank;
    end else begin
      issue_ok_s = 1'b1;
    end
`ifdef DRAW_CLIP_EN
    if (push && ((32'(push_x) >= 32'(SCREEN_W)) || (32'(push_y) >= 32'(SCREEN_H)))) begin
      clip_s = 1'b1;
    end else begin
      clip_s = 1'b0;
    end
`endif
    // flush beats the issue condition, so nothing is popped on a flush cycle
    pop_s     = (state_r == ST_IDLE) && !empty_r && issue_ok_s && !flush;
    push_ok_s = push && !flush && !clip_s && (!full_r || pop_s);
    drop_s    = push && !flush && !clip_s && full_r && !pop_s;
  end

  // Queue slot selection; in LIFO mode a simultaneous push reuses the popped top slot
  always_comb begin
    rd_idx_s = rd_ptr_r;
    wr_idx_s = wr_ptr_r;
    if (LIFO != 32'sd0) begin
      rd_idx_s = count_r[PTR_W-1:0] - PTR_W'(1'b1);
      if (pop_s) begin
        wr_idx_s = rd_idx_s;
      end else begin
        wr_idx_s = count_r[PTR_W-1:0];
      end
    end else begin
      rd_idx_s = rd_ptr_r;
      wr_idx_s = wr_ptr_r;
    end
    rd_entry_s = mem_r[rd_idx_s];
  end

  // Next occupancy
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = '0;
    end else begin
      case ({push_ok_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Queue storage
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_idx_s] <= {push_id, push_x, push_y};
    end
  end

  // Pointers, occupancy flags and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == '0);
      if (flush) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
      end else begin
        if (push_ok_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
        end
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Transaction FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_finish && draw_finish) begin
          state_nxt_s = ST_IDLE;
        end else if (load_finish) begin
          state_nxt_s = ST_DRAW;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_DRAW: begin
        if (draw_finish) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAW;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Transaction FSM state register and busy flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Issued request registers, held stable through LOAD
  always_ff @(posedge clock) begin
    if (reset) begin
      load_r    <= 1'b0;
      load_id_r <= '0;
      load_x_r  <= '0;
      load_y_r  <= '0;
    end else if (pop_s) begin
      load_r    <= 1'b1;
      load_id_r <= rd_entry_s[ENTRY_W-1 -: ID_WIDTH];
      load_x_r  <= rd_entry_s[X_WIDTH+Y_WIDTH-1 -: X_WIDTH];
      load_y_r  <= rd_entry_s[Y_WIDTH-1:0];
    end else if ((state_r == ST_LOAD) && load_finish) begin
      load_r <= 1'b0;
    end
  end

`ifdef DRAW_CLIP_EN
  logic clipped_r;

  // One-cycle notice of a rejected off-screen request
  always_ff @(posedge clock) begin
    if (reset) begin
      clipped_r <= 1'b0;
    end else begin
      clipped_r <= clip_s;
    end
  end

  assign clipped = clipped_r;
`endif

  assign load              = load_r;
  assign load_character_id = load_id_r;
  assign load_x            = load_x_r;
  assign load_y            = load_y_r;
  assign busy              = busy_r;
  assign count             = count_r;
  assign full              = full_r;
  assign empty             = empty_r;
  assign overflow          = overflow_r;

endmodule
